// File: rtl/seq_det_pkg.sv
// Shared elaboration-time helpers for the serial pattern detector.
// Pattern bits are indexed from the first expected bit: position i lives in pattern[len-1-i].
package seq_det_pkg;

   localparam int MAX_PAT_LEN = 16;
   localparam int STATE_W     = $clog2(MAX_PAT_LEN + 1);

   typedef logic [STATE_W-1:0] state_t;

   function automatic logic pat_bit(logic [MAX_PAT_LEN-1:0] pattern, int len, int i);
      return pattern[4'(len - 1 - i)];
   endfunction

   // Longest proper prefix of the first k pattern bits that is also their suffix.
   function automatic int fail_len(logic [MAX_PAT_LEN-1:0] pattern, int len, int k);
      int  best;
      logic ok;
      best = 0;
      for (int l = 1; l < k; l++) begin
         ok = 1'b1;
         for (int j = 0; j < l; j++)
            if (pat_bit(pattern, len, j) != pat_bit(pattern, len, k - l + j)) ok = 1'b0;
         if (ok) best = l;
      end
      return best;
   endfunction

   // Longest pattern prefix that is a suffix of (matched prefix of length state) followed by b.
   function automatic int next_len(logic [MAX_PAT_LEN-1:0] pattern, int len, state_t state,
                                   logic b);
      int   st;
      int   best;
      int   idx;
      logic ok;
      logic c;
      st   = int'(state);
      best = 0;
      for (int l = 1; l <= st + 1; l++) begin
         if (l <= len) begin
            ok = 1'b1;
            for (int j = 0; j < l; j++) begin
               idx = st + 1 - l + j;
               c   = (idx < st) ? pat_bit(pattern, len, idx) : b;
               if (c != pat_bit(pattern, len, j)) ok = 1'b0;
            end
            if (ok) best = l;
         end
      end
      return best;
   endfunction

endpackage

// File: rtl/seq_detector_if.sv
// Bus bundle for seq_detector: qualified serial input plus match outputs.
// in/overlap/clr are sampled on a rising edge only; in is consumed only when in_valid=1 (no ready, never stalls).
interface seq_detector_if #(
   parameter int PAT_LEN = 4,
   parameter int CNT_W   = 8
);
   localparam int ML_W = $clog2(PAT_LEN + 1);

   logic             clr;
   logic             in_valid;
   logic             in;
   logic             overlap;
   logic             out;
   logic [ML_W-1:0]  match_len;
   logic [CNT_W-1:0] match_cnt;

   modport master (
      output clr, in_valid, in, overlap,
      input  out, match_len, match_cnt
   );

   modport slave (
      input  clr, in_valid, in, overlap,
      output out, match_len, match_cnt
   );
endinterface

// File: rtl/seq_next_state.sv
// Combinational KMP transition lookup: (matched length, input bit) -> next length and match flag.
// Both tables are constant-folded from the package functions at elaboration.
module seq_next_state
   import seq_det_pkg::*;
#(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
   localparam int                ML_W    = $clog2(PAT_LEN + 1)
) (
   input  logic [ML_W-1:0] state,
   input  logic            in,
   output logic [ML_W-1:0] nl,
   output logic            hit
);
   localparam int N = 2 ** ML_W;

   logic [ML_W-1:0] tab0 [N];
   logic [ML_W-1:0] tab1 [N];

   for (genvar s = 0; s < N; s++) begin : g_tab
      if (s < PAT_LEN) begin : g_live
         assign tab0[s] = ML_W'(next_len(16'(PATTERN), PAT_LEN, state_t'(s), 1'b0));
         assign tab1[s] = ML_W'(next_len(16'(PATTERN), PAT_LEN, state_t'(s), 1'b1));
      end else begin : g_unreach
         assign tab0[s] = '0;
         assign tab1[s] = '0;
      end
   end

   always_comb begin
      nl  = in ? tab1[state] : tab0[state];
      hit = (nl == ML_W'(PAT_LEN));
   end
endmodule

// File: rtl/seq_detector.sv
// Serial bit-pattern detector with run-time overlap selection; match_len exposes the FSM state.
// Define SEQ_DETECTOR_CNT_EN to build the saturating match counter; otherwise match_cnt is tied to 0.
module seq_detector
   import seq_det_pkg::*;
#(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
   parameter int                 CNT_W   = 8
) (
   input  logic          clk,
   input  logic          rst,
   seq_detector_if.slave bus
);
   localparam int              ML_W   = $clog2(PAT_LEN + 1);
   localparam logic [ML_W-1:0] FAIL_S = ML_W'(fail_len(16'(PATTERN), PAT_LEN, PAT_LEN));

   logic [ML_W-1:0] state_q, state_d;
   logic            out_q, out_d;
   logic [ML_W-1:0] nl;
   logic            hit;

   seq_next_state #(
      .PAT_LEN (PAT_LEN),
      .PATTERN (PATTERN)
   ) u_next (
      .state (state_q),
      .in    (bus.in),
      .nl    (nl),
      .hit   (hit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= '0;
         out_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
      end
   end

   // Full length is never held: a match collapses straight to the restart point.
   always_comb begin
      state_d = state_q;
      out_d   = 1'b0;
      if (bus.clr) begin
         state_d = '0;
      end else if (bus.in_valid) begin
         if (hit) begin
            out_d   = 1'b1;
            state_d = bus.overlap ? FAIL_S : '0;
         end else begin
            state_d = nl;
         end
      end
   end

   assign bus.out       = out_q;
   assign bus.match_len = state_q;

`ifdef SEQ_DETECTOR_CNT_EN
   logic             match_ev;
   logic [CNT_W-1:0] cnt_q;

   assign match_ev = !bus.clr && bus.in_valid && hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                        cnt_q <= '0;
      else if (bus.clr)               cnt_q <= '0;
      else if (match_ev && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
   end

   assign bus.match_cnt = cnt_q;
`else
   assign bus.match_cnt = '0;
`endif
endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector: default 1101 detector plus a PAT_LEN=2 "11" instance.
// Expected {out, match_len, match_cnt} tuples are queued when stimulus is driven and checked after the edge.
module tb_seq_detector;
   logic clk;
   logic rst;

   int total = 0;
   int bad   = 0;

   seq_detector_if #(.PAT_LEN(4), .CNT_W(8)) a_if ();
   seq_detector_if #(.PAT_LEN(2), .CNT_W(2)) b_if ();

   seq_detector #(.PAT_LEN(4), .PATTERN(4'b1101), .CNT_W(8)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (a_if.slave)
   );

   seq_detector #(.PAT_LEN(2), .PATTERN(2'b11), .CNT_W(2)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (b_if.slave)
   );

   localparam int WA = 12;
   localparam int WB = 5;
   logic [WA-1:0] exp_q[$];
   logic [WB-1:0] exp_b_q[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int cnt_exp(int n);
`ifdef SEQ_DETECTOR_CNT_EN
      return n;
`else
      return 0 * n;
`endif
   endfunction

   task automatic check_a(string tag);
      logic [WA-1:0] e;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s a: expected queue empty got n/a want entry", tag);
      end else begin
         e = exp_q.pop_front();
         total++;
         assert (a_if.out === e[11]) else begin
            bad++;
            $error("FAIL %s a.out: got %b want %b", tag, a_if.out, e[11]);
         end
         total++;
         assert (a_if.match_len === e[10:8]) else begin
            bad++;
            $error("FAIL %s a.match_len: got %0d want %0d", tag, a_if.match_len, e[10:8]);
         end
         total++;
         assert (a_if.match_cnt === e[7:0]) else begin
            bad++;
            $error("FAIL %s a.match_cnt: got %0d want %0d", tag, a_if.match_cnt, e[7:0]);
         end
      end
   endtask

   task automatic check_b(string tag);
      logic [WB-1:0] e;
      if (exp_b_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s b: expected queue empty got n/a want entry", tag);
      end else begin
         e = exp_b_q.pop_front();
         total++;
         assert (b_if.out === e[4]) else begin
            bad++;
            $error("FAIL %s b.out: got %b want %b", tag, b_if.out, e[4]);
         end
         total++;
         assert (b_if.match_len === e[3:2]) else begin
            bad++;
            $error("FAIL %s b.match_len: got %0d want %0d", tag, b_if.match_len, e[3:2]);
         end
         total++;
         assert (b_if.match_cnt === e[1:0]) else begin
            bad++;
            $error("FAIL %s b.match_cnt: got %0d want %0d", tag, b_if.match_cnt, e[1:0]);
         end
      end
   endtask

   task automatic step_a(string tag, logic c, logic v, logic b, logic ov,
                         logic eo, int el, int ec);
      exp_q.push_back({eo, 3'(el), 8'(cnt_exp(ec))});
      @(negedge clk);
      a_if.clr      = c;
      a_if.in_valid = v;
      a_if.in       = b;
      a_if.overlap  = ov;
      @(posedge clk);
      #1;
      check_a(tag);
   endtask

   task automatic step_b(string tag, logic v, logic b, logic eo, int el, int ec);
      exp_b_q.push_back({eo, 2'(el), 2'(cnt_exp(ec))});
      @(negedge clk);
      b_if.in_valid = v;
      b_if.in       = b;
      @(posedge clk);
      #1;
      check_b(tag);
   endtask

   initial begin
      rst = 1'b1;
      a_if.clr = 1'b0; a_if.in_valid = 1'b0; a_if.in = 1'b0; a_if.overlap = 1'b1;
      b_if.clr = 1'b0; b_if.in_valid = 1'b0; b_if.in = 1'b0; b_if.overlap = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back({1'b0, 3'd0, 8'd0});
      check_a("reset");
      exp_b_q.push_back({1'b0, 2'd0, 2'd0});
      check_b("reset");
      @(negedge clk);
      rst = 1'b0;

      // overlapping: 1101101 -> pulses after bits 4 and 7
      step_a("ov_b1", 0, 1, 1, 1, 0, 1, 0);
      step_a("ov_b2", 0, 1, 1, 1, 0, 2, 0);
      step_a("ov_b3", 0, 1, 0, 1, 0, 3, 0);
      step_a("ov_b4", 0, 1, 1, 1, 1, 1, 1);
      step_a("ov_b5", 0, 1, 1, 1, 0, 2, 1);
      step_a("ov_b6", 0, 1, 0, 1, 0, 3, 1);
      step_a("ov_b7", 0, 1, 1, 1, 1, 1, 2);
      step_a("ov_clr", 1, 0, 0, 1, 0, 0, 0);

      // non-overlapping: single pulse, restart from 0
      step_a("no_b1", 0, 1, 1, 0, 0, 1, 0);
      step_a("no_b2", 0, 1, 1, 0, 0, 2, 0);
      step_a("no_b3", 0, 1, 0, 0, 0, 3, 0);
      step_a("no_b4", 0, 1, 1, 0, 1, 0, 1);
      step_a("no_b5", 0, 1, 1, 0, 0, 1, 1);
      step_a("no_b6", 0, 1, 0, 0, 0, 0, 1);
      step_a("no_b7", 0, 1, 1, 0, 0, 1, 1);
      step_a("no_clr", 1, 0, 0, 1, 0, 0, 0);

      // in_valid gap holds the partial match
      step_a("gap_b1", 0, 1, 1, 1, 0, 1, 0);
      step_a("gap_b2", 0, 1, 1, 1, 0, 2, 0);
      step_a("gap_b3", 0, 1, 0, 1, 0, 3, 0);
      for (int i = 0; i < 5; i++)
         step_a("gap_idle", 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 3, 0);
      step_a("gap_b4", 0, 1, 1, 1, 1, 1, 1);
      step_a("gap_after", 0, 0, 0, 1, 0, 1, 1);
      step_a("gap_clr", 1, 0, 0, 1, 0, 0, 0);

      // clear coincident with the final bit
      step_a("clr_b1", 0, 1, 1, 1, 0, 1, 0);
      step_a("clr_b2", 0, 1, 1, 1, 0, 2, 0);
      step_a("clr_b3", 0, 1, 0, 1, 0, 3, 0);
      step_a("clr_b4", 1, 1, 1, 1, 0, 0, 0);
      step_a("clr_after", 0, 0, 0, 1, 0, 0, 0);

      // asynchronous reset mid-sequence
      step_a("rst_b1", 0, 1, 1, 1, 0, 1, 0);
      step_a("rst_b2", 0, 1, 1, 1, 0, 2, 0);
      step_a("rst_b3", 0, 1, 0, 1, 0, 3, 0);
      @(negedge clk);
      #2;
      a_if.in_valid = 1'b0;
      rst = 1'b1;
      #1;
      exp_q.push_back({1'b0, 3'd0, 8'd0});
      check_a("rst_async");
      @(negedge clk);
      rst = 1'b0;
      step_a("rst_post1", 0, 1, 1, 1, 0, 1, 0);
      step_a("rst_f1", 0, 1, 1, 1, 0, 2, 0);
      step_a("rst_f2", 0, 1, 1, 1, 0, 2, 0);
      step_a("rst_f3", 0, 1, 0, 1, 0, 3, 0);
      step_a("rst_f4", 0, 1, 1, 1, 1, 1, 1);
      step_a("rst_idle", 0, 0, 0, 1, 0, 1, 1);

      // PAT_LEN=2 "11": back-to-back pulses and counter saturation
      step_b("b_1", 1, 1, 0, 1, 0);
      step_b("b_2", 1, 1, 1, 1, 1);
      step_b("b_3", 1, 1, 1, 1, 2);
      step_b("b_4", 1, 1, 1, 1, 3);
      step_b("b_5", 1, 1, 1, 1, 3);
      step_b("b_6", 1, 1, 1, 1, 3);
      step_b("b_idle", 0, 0, 0, 1, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/seq_detector.md
# seq_detector

Parametrised serial bit-pattern detector, the configurable successor to the team's fixed-sequence FSM exercises. It consumes one qualified input bit per clock and tracks the longest matched prefix with a KMP-style state machine. It pulses `out` on every completed match, with run-time selection of overlapping or non-overlapping detection. An optional saturating match counter supports lab measurement.

## Interface
- `PAT_LEN`, default 4: pattern length in bits; legal range 2..16.
- `PATTERN`, default 4'b1101: target sequence; `PATTERN[PAT_LEN-1]` is the first bit expected.
- `CNT_W`, default 8: match counter width.
- `clk`, input, 1: sole clock; all state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `clr`, input, 1: synchronous clear.
- `in_valid`, input, 1: `in` is sampled only when this is 1.
- `in`, input, 1: serial data bit.
- `overlap`, input, 1: 1 selects overlapping detection; 0 selects non-overlapping.
- `out`, output, 1: one-cycle match pulse.
- `match_len`, output, `$clog2(PAT_LEN+1)`: current matched-prefix length (the FSM state).
- `match_cnt`, output, `CNT_W`: number of matches seen, saturating.

## Operation
- State S = number of pattern bits currently matched, 0..PAT_LEN-1. State PAT_LEN is never held.
- On an edge with `in_valid`=1, form the candidate string = matched prefix followed by `in`. The next length is the longest prefix of `PATTERN` that is a suffix of that candidate.
- When the next length equals PAT_LEN, a match occurs:
  - `out` is set to 1.
  - If `overlap`=1, S becomes fail(PAT_LEN), the longest proper prefix of `PATTERN` that is also its suffix.
  - If `overlap`=0, S becomes 0.
- `overlap` is sampled only on the match edge. Changing it mid-sequence has no other effect.
- On an edge with `in_valid`=0, S holds and `out` goes to 0.
- `clr`=1 forces S=0, `out`=0 and `match_cnt`=0. It overrides `in_valid`.
- `match_cnt` increments on each match and sticks at all-ones.
- The failure table is computed at elaboration from `PATTERN`. No runtime tables exist.

## Timing
- Reset values: S=0, `out`=0, `match_len`=0, `match_cnt`=0. Reset applies immediately and asynchronously.
- Reset asserted mid-sequence discards any partial match. Detection restarts from the first bit accepted after deassertion.
- Latency: `out` is high for exactly the cycle after the edge that accepted the final pattern bit.
- Back-to-back matches (possible only when `overlap`=1 and fail(PAT_LEN)=PAT_LEN-1) hold `out` high on consecutive cycles.
- `match_len` and `match_cnt` update on the same edge as `out`.
- No combinational path from any input to any output.

## Configuration
- `SEQ_DETECTOR_CNT_EN` defined: the `match_cnt` register and its saturating incrementer are built as described above.
- Macro undefined:
  - The `match_cnt` port still exists but is tied to 0.
  - No counter flops are synthesised.
  - All other behaviour is identical.

## Structure
- Shared package `seq_det_pkg`:
  - Elaboration function `fail_len(pattern, len, k)`.
  - Elaboration function `next_len(pattern, len, state, bit)`.
  - Constant for the maximum `PAT_LEN` (16).
  - Typedef for the state width.
- One sub-module, `seq_next_state`: combinational lookup from (S, `in`) to the next length plus a match flag, generated from the package functions.
- Top level holds the S register, `out` register, counter and clear/reset priority.

## Test plan
- Defaults, `overlap`=1, stream 1,1,0,1,1,0,1 with `in_valid`=1:
  - `out` pulses after the 4th and 7th bits.
  - `match_cnt`=2.
  - `match_len` after the 4th bit is 1.
- Same stream with `overlap`=0: single pulse after the 4th bit; `match_cnt`=1; S=0 after the match.
- Stream 1,1,0 then `in_valid`=0 for 5 cycles, then 1: `match_len` holds 3 across the gap; `out` pulses once after the final bit.
- Stream 1,1,0, then assert `rst` asynchronously mid-cycle, then send 1: `match_len`=0 immediately on reset and no pulse follows; a fresh 1,1,0,1 produces a match.
- `clr`=1 coincident with the final bit of 1,1,0,1: no pulse; `match_len`=0; `match_cnt`=0.
- PAT_LEN=2, `PATTERN`=2'b11, `CNT_W`=2, `overlap`=1, six consecutive 1s:
  - `out` is high for 5 consecutive cycles.
  - `match_cnt` saturates at 3.
  - With the macro undefined, `match_cnt` stays 0.
